// File: rtl/cpu_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  localparam int PC_W_DEFAULT         = 10;
  localparam int FLUSH_CYCLES_DEFAULT = 2;
  localparam int FLUSH_CNT_W          = 3;  // holds flush depths 1..7

endpackage

// File: rtl/pc_seq_flush_timer.sv
// Loadable down-counter with a zero flag; times the wrong-path flush window.
module pc_seq_flush_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_value;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: IDLE/RUN/FLUSH/HALT control of the program counter.
// Optional cycle_count output is enabled by defining PC_SEQ_CYCLE_CNT_EN.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int             PC_W         = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int             FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            halt,
  input  logic            branch,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            stall,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            flush,
  output logic            done,
  output logic            busy
`ifdef PC_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]     cycle_count
`endif
);

  seq_state_t      state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic            timer_load, timer_dec, timer_zero;
  logic            take_branch;

  assign take_branch = branch && branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Event priority in RUN: taken branch, then halt, then stall.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    fetch_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (take_branch) begin
          fetch_valid = 1'b1;
          pc_next     = branch_target;
          state_next  = FLUSH;
          timer_load  = 1'b1;
        end else if (halt) begin
          fetch_valid = 1'b1;
          state_next  = HALT;
        end else if (!stall) begin
          fetch_valid = 1'b1;
          pc_next     = pc_reg + PC_W'(1);
        end
      end
      FLUSH: begin
        if (timer_zero) state_next = RUN;
        else            timer_dec  = 1'b1;
      end
      HALT: begin
        if (start) begin
          pc_next    = RESET_PC;
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Loaded with depth-1 so the zero flag marks the final flush cycle.
  pc_seq_flush_timer #(
    .CNT_W(FLUSH_CNT_W)
  ) u_flush_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(FLUSH_CNT_W'(FLUSH_CYCLES - 1)),
    .dec       (timer_dec),
    .zero      (timer_zero)
  );

  assign pc    = pc_reg;
  assign flush = (state_reg == FLUSH);
  assign done  = (state_reg == HALT);
  assign busy  = (state_reg == RUN) || (state_reg == FLUSH);

`ifdef PC_SEQ_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_reg <= '0;
    end else if ((state_reg == HALT) && start) begin
      cycle_cnt_reg <= '0;
    end else if (busy && (cycle_cnt_reg != '1)) begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
    end
  end

  assign cycle_count = cycle_cnt_reg;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes model expectations, monitor compares.
module tb_pc_sequencer;

  localparam int PC_W   = 10;
  localparam int PC_MOD = 1 << PC_W;
  localparam int FLUSHN = 2;

  localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_HALT = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0, start = 1'b0, halt = 1'b0;
  logic            branch = 1'b0, branch_taken = 1'b0, stall = 1'b0;
  logic [PC_W-1:0] branch_target = '0;
  logic [PC_W-1:0] pc;
  logic            fetch_valid, flush, done, busy;
`ifdef PC_SEQ_CYCLE_CNT_EN
  logic [31:0]     cycle_count;
`endif

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .halt         (halt),
    .branch       (branch),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .stall        (stall),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .done         (done),
    .busy         (busy)
`ifdef PC_SEQ_CYCLE_CNT_EN
    ,
    .cycle_count  (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int     pc;
    bit     fv;
    bit     fl;
    bit     dn;
    bit     bz;
    longint cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_compared = 0;
  int   n_mismatched = 0;

  // Reference model state
  bit     m_known = 0;
  int     m_mode, m_pc, m_left;
  longint m_cnt;

  task automatic chk(input string name, input longint act, input longint req);
    n_compared++;
    if (act != req) begin
      n_mismatched++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, req);
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit hl, input bit br,
                      input bit tk, input int tgt, input bit sl);
    exp_t e;
    bit   taken;
    @(negedge clk);
    reset = rst; start = st; halt = hl; branch = br; branch_taken = tk;
    branch_target = PC_W'(tgt); stall = sl;
    taken = br && tk;
    if (m_known) begin
      e.pc  = m_pc;
      e.fl  = (m_mode == M_FLUSH);
      e.dn  = (m_mode == M_HALT);
      e.bz  = (m_mode == M_RUN) || (m_mode == M_FLUSH);
      // A stall only suppresses the fetch when nothing higher-priority happens.
      e.fv  = (m_mode == M_RUN) && !(sl && !taken && !hl);
      e.cnt = m_cnt;
      sb_q.push_back(e);
      if (rst) begin
        m_mode = M_IDLE; m_pc = 0; m_left = 0; m_cnt = 0;
      end else begin
        if (m_mode == M_HALT && st) m_cnt = 0;
        else if (e.bz && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        case (m_mode)
          M_IDLE: if (st) m_mode = M_RUN;
          M_RUN: begin
            if (taken) begin
              m_pc = tgt % PC_MOD; m_mode = M_FLUSH; m_left = FLUSHN;
            end else if (hl) m_mode = M_HALT;
            else if (!sl) m_pc = (m_pc + 1) % PC_MOD;
          end
          M_FLUSH: begin
            m_left--;
            if (m_left == 0) m_mode = M_RUN;
          end
          default: if (st) begin m_pc = 0; m_mode = M_RUN; end
        endcase
      end
    end else if (rst) begin
      m_known = 1; m_mode = M_IDLE; m_pc = 0; m_left = 0; m_cnt = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle, sampled after inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc", pc, e.pc);
        chk("fetch_valid", fetch_valid, e.fv);
        chk("flush", flush, e.fl);
        chk("done", done, e.dn);
        chk("busy", busy, e.bz);
`ifdef PC_SEQ_CYCLE_CNT_EN
        chk("cycle_count", cycle_count, e.cnt);
`endif
        $display("cyc @%0t pc=%03h fv=%0b flush=%0b done=%0b busy=%0b",
                 $time, pc, fetch_valid, flush, done, busy);
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // start then free-run: 0,0,1,2,3,4
    step(0, 1, 0, 0, 0, 0, 0);
    idle(6);
    // taken branch at pc=6
    step(0, 0, 0, 1, 1, 'h3A0, 0);
    idle(4);
    // not-taken branch is no event
    step(0, 0, 0, 1, 0, 'h155, 0);
    // branch + halt + stall together, then events during FLUSH are ignored
    step(0, 0, 1, 1, 1, 'h10, 1);
    step(0, 1, 1, 1, 1, 'h222, 1);
    idle(3);
    // wrap through 0x3FF, then stall at 0x005
    step(0, 0, 0, 1, 1, 'h3FE, 0);
    idle(9);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // halt at pc=9, restart
    step(0, 0, 0, 1, 1, 9, 0);
    idle(2);
    step(0, 0, 1, 0, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(2);
    // reset in first FLUSH cycle
    step(0, 0, 0, 1, 1, 'h0AB, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199) == 0, $urandom_range(7) == 0, $urandom_range(19) == 0,
           $urandom_range(5) == 0, $urandom_range(1) == 1,
           int'($urandom_range(PC_MOD - 1)), $urandom_range(4) == 0);
    end
    idle(2);
    @(negedge clk);
    #5;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): PC_W, 10, program counter width; RESET_PC, 0, restart/reset fetch address; FLUSH_CYCLES, 2, wrong-path flush duration (1..7).
REQ-002 SHALL have ports (name, direction, width, meaning), listed one per line:
  clk  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high reset
  start  in  1  begin/restart execution pulse
  halt  in  1  decoded halt instruction present in decode stage
  branch  in  1  branch/jump instruction resolving in execute
  branch_taken  in  1  ALU branch condition result
  branch_target  in  PC_W  absolute redirect address
  stall  in  1  hazard stall request
  pc  out  PC_W  current fetch address
  fetch_valid  out  1  fetch at pc is architecturally valid
  flush  out  1  kill younger in-flight instructions
  done  out  1  program halted, sticky
  busy  out  1  state is RUN or FLUSH
REQ-003 SHALL use clock port clk and reset port reset; reset is synchronous and active-high, and there is exactly one clock.

Function
REQ-004 SHALL implement the states IDLE, RUN, FLUSH, and HALT.
REQ-005 In IDLE, pc SHALL be RESET_PC and fetch_valid SHALL be 0; start=1 moves to RUN on the next edge with pc unchanged.
REQ-006 In RUN with no event, pc SHALL increment by 1 each cycle, modulo 2^PC_W (all-ones wraps to 0), and fetch_valid SHALL be 1.
REQ-007 In RUN with stall=1, pc SHALL hold and fetch_valid SHALL be 0 for that cycle; there are no latency bubbles after stall drops.
REQ-008 In RUN with branch & branch_taken, pc SHALL load branch_target on the next edge and the state SHALL move to FLUSH.
REQ-009 branch=1 with branch_taken=0 SHALL be treated as no event.
REQ-010 In FLUSH, flush=1, fetch_valid=0, and pc holds the target for exactly FLUSH_CYCLES cycles, then RUN fetches the target with fetch_valid=1.
REQ-011 In RUN with halt=1, the state SHALL move to HALT with pc held; done goes to 1 on the same edge.
REQ-012 Simultaneous events in RUN SHALL be prioritised: taken branch > halt > stall. An older taken branch discards the wrong-path halt.
REQ-013 In FLUSH, stall, halt and branch SHALL be ignored, and the flush counter SHALL be unaffected.
REQ-014 start SHALL be ignored in RUN and FLUSH.
REQ-015 In HALT, fetch_valid=0 and done=1; start=1 SHALL set pc to RESET_PC, clear done, and move to RUN on the next edge.
REQ-016 busy SHALL be a combinational decode of the state, with no extra latency.

Reset
REQ-017 When reset=1 at an edge: state IDLE, pc=RESET_PC, fetch_valid=0, flush=0, done=0, busy=0, flush counter=0, and cycle_count=0 if present.
REQ-018 Reset SHALL take priority over all inputs in every state, including mid-FLUSH; no partial flush persists.

Configuration
REQ-019 Macro PC_SEQ_CYCLE_CNT_EN, when defined, SHALL add output cycle_count (32 bits) counting cycles spent in RUN or FLUSH. The counter saturates at all-ones, clears on reset, and clears on start from HALT.
REQ-020 When PC_SEQ_CYCLE_CNT_EN is undefined, the cycle_count port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-021 The shared package cpu_pkg SHALL hold the state enum (IDLE, RUN, FLUSH, HALT), the default PC width constant, and the default flush depth.
REQ-022 There SHALL be one sub-module, pc_seq_flush_timer: a loadable down-counter with a zero flag used for the FLUSH duration. All other logic SHALL be in pc_sequencer.

Verification
REQ-023 Reset, then start pulse, then 5 idle cycles -> pc sequence 0,0,1,2,3,4; fetch_valid=1 from the first RUN cycle.
REQ-024 In RUN at pc=6, branch=1, taken=1, target=0x3A0 -> flush=1 and fetch_valid=0 for 2 cycles with pc=0x3A0, then pc advances 0x3A0, 0x3A1.
REQ-025 Same cycle: taken branch to 0x10 and halt=1 and stall=1 -> FLUSH entered, done stays 0, pc=0x10.
REQ-026 pc=0x3FF with no event -> next pc=0x000; stall for 3 cycles at pc=0x005 -> pc holds 0x005, then resumes 0x006.
REQ-027 halt at pc=9 -> done=1 and pc stays 9; start -> pc=0, done=0, RUN. Reset asserted in cycle 1 of FLUSH -> IDLE and flush=0 next cycle.
REQ-028 With PC_SEQ_CYCLE_CNT_EN defined: 10 RUN + 2 FLUSH cycles -> cycle_count=12. Without the macro, the design elaborates with no cycle_count port.
